// File: rtl/pu_riscv_dext_mq_pkg.sv
// Shared types for the PU-RISCV data external access path: tracking-queue
// entry layout and AHB-style transfer size encodings.
package pu_riscv_dext_pkg;

   typedef struct packed {
      logic       discard;
      logic       we;
      logic [2:0] size;
      logic [2:0] adr_lo;
   } dext_entry_t;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HWORD = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

endpackage

// File: rtl/pu_riscv_dext_mq_if.sv
// LSU-side and BIU-side signal bundle of the data external access block.
// slave: the access block itself; master: whatever drives the LSU and BIU ends.
interface pu_riscv_dext_mq_if #(
   parameter int XLEN = 64,
   parameter int PLEN = 64
);
   logic            clr_i;
   logic            mem_req_i;
   logic [XLEN-1:0] mem_adr_i;
   logic [2:0]      mem_size_i;
   logic [2:0]      mem_type_i;
   logic            mem_lock_i;
   logic [2:0]      mem_prot_i;
   logic            mem_we_i;
   logic [XLEN-1:0] mem_d_i;
   logic            mem_adr_ack_o;
   logic [PLEN-1:0] mem_adr_o;
   logic [XLEN-1:0] mem_q_o;
   logic            mem_ack_o;
   logic            mem_err_o;
   logic            mem_busy_o;
   logic            biu_stb_o;
   logic            biu_stb_ack_i;
   logic [PLEN-1:0] biu_adri_o;
   logic [PLEN-1:0] biu_adro_i;
   logic [2:0]      biu_size_o;
   logic [2:0]      biu_type_o;
   logic            biu_lock_o;
   logic [2:0]      biu_prot_o;
   logic            biu_we_o;
   logic [XLEN-1:0] biu_d_o;
   logic [XLEN-1:0] biu_q_i;
   logic            biu_ack_i;
   logic            biu_err_i;

   modport slave (
      input  clr_i, mem_req_i, mem_adr_i, mem_size_i, mem_type_i, mem_lock_i,
             mem_prot_i, mem_we_i, mem_d_i, biu_stb_ack_i, biu_adro_i,
             biu_q_i, biu_ack_i, biu_err_i,
      output mem_adr_ack_o, mem_adr_o, mem_q_o, mem_ack_o, mem_err_o,
             mem_busy_o, biu_stb_o, biu_adri_o, biu_size_o, biu_type_o,
             biu_lock_o, biu_prot_o, biu_we_o, biu_d_o
   );

   modport master (
      output clr_i, mem_req_i, mem_adr_i, mem_size_i, mem_type_i, mem_lock_i,
             mem_prot_i, mem_we_i, mem_d_i, biu_stb_ack_i, biu_adro_i,
             biu_q_i, biu_ack_i, biu_err_i,
      input  mem_adr_ack_o, mem_adr_o, mem_q_o, mem_ack_o, mem_err_o,
             mem_busy_o, biu_stb_o, biu_adri_o, biu_size_o, biu_type_o,
             biu_lock_o, biu_prot_o, biu_we_o, biu_d_o
   );
endinterface

// File: rtl/pu_riscv_dext_mq_tagq.sv
// Circular tracking queue for outstanding bus transactions; clr_mark_i flags
// every valid entry so its eventual response is swallowed.
module pu_riscv_dext_tagq
   import pu_riscv_dext_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  dext_entry_t              push_data_i,
   input  logic                     pop_i,
   input  logic                     clr_mark_i,
   output dext_entry_t              head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   dext_entry_t         r_mem [DEPTH];
   logic [AW-1:0]       r_wp, r_rp;
   logic [CW-1:0]       r_cnt;
   logic [DEPTH-1:0]    w_valid;
   logic                w_push, w_pop;

   assign full_o  = (r_cnt == CW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign count_o = r_cnt;
   assign head_o  = r_mem[r_rp];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   // Slot i is live when its distance from the read pointer is below count.
   always_comb begin
      w_valid = '0;
      for (int i = 0; i < DEPTH; i++)
         w_valid[i] = ({1'b0, AW'(i) - r_rp} < r_cnt);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (clr_mark_i)
            for (int i = 0; i < DEPTH; i++)
               if (w_valid[i]) r_mem[i].discard <= 1'b1;
         if (w_push) begin
            r_mem[r_wp] <= push_data_i;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/pu_riscv_dext_mq.sv
// Data external access: holds stalled requests toward the BIU, tracks up to DEPTH
// outstanding transfers and drops responses flushed by clr_i.
// Optional: PU_RISCV_DEXT_LOAD_ALIGN_EN aligns/zero-extends read data per request.
module pu_riscv_dext_mq
   import pu_riscv_dext_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int PLEN  = 64,
   parameter int DEPTH = 4
)(
   input logic               clk_i,
   input logic               rst_ni,
   pu_riscv_dext_mq_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            r_hold_vld;
   logic [PLEN-1:0] r_adr;
   logic [2:0]      r_size, r_type, r_prot;
   logic            r_lock, r_we;
   logic [XLEN-1:0] r_d;

   logic            w_full, w_empty, w_stb, w_issue, w_resp, w_qual, w_hold_nxt;
   dext_entry_t     w_head, w_push_ent;
   logic [CW-1:0]   w_count;
   logic            w_unused;

   assign w_stb      = (bus.mem_req_i | r_hold_vld) & ~bus.clr_i & ~w_full;
   assign w_issue    = w_stb & bus.biu_stb_ack_i;
   assign w_hold_nxt = bus.clr_i ? 1'b0 : (bus.mem_req_i | r_hold_vld) & ~w_issue;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_hold_vld <= 1'b0;
         r_adr      <= '0;
         r_size     <= '0;
         r_type     <= '0;
         r_prot     <= '0;
         r_lock     <= 1'b0;
         r_we       <= 1'b0;
         r_d        <= '0;
      end else begin
         r_hold_vld <= w_hold_nxt;
         if (bus.mem_req_i && !r_hold_vld) begin
            r_adr  <= PLEN'(bus.mem_adr_i);
            r_size <= bus.mem_size_i;
            r_type <= bus.mem_type_i;
            r_prot <= bus.mem_prot_i;
            r_lock <= bus.mem_lock_i;
            r_we   <= bus.mem_we_i;
            r_d    <= bus.mem_d_i;
         end
      end
   end

   assign bus.biu_stb_o     = w_stb;
   assign bus.mem_adr_ack_o = w_issue;
   assign bus.biu_adri_o    = r_hold_vld ? r_adr  : PLEN'(bus.mem_adr_i);
   assign bus.biu_size_o    = r_hold_vld ? r_size : bus.mem_size_i;
   assign bus.biu_type_o    = r_hold_vld ? r_type : bus.mem_type_i;
   assign bus.biu_prot_o    = r_hold_vld ? r_prot : bus.mem_prot_i;
   assign bus.biu_lock_o    = r_hold_vld ? r_lock : bus.mem_lock_i;
   assign bus.biu_we_o      = r_hold_vld ? r_we   : bus.mem_we_i;
   assign bus.biu_d_o       = r_hold_vld ? r_d    : bus.mem_d_i;

   always_comb begin
      w_push_ent      = '0;
      w_push_ent.we   = bus.biu_we_o;
      w_push_ent.size = bus.biu_size_o;
`ifdef PU_RISCV_DEXT_LOAD_ALIGN_EN
      w_push_ent.adr_lo = bus.biu_adri_o[2:0];
`endif
   end

   assign w_resp = bus.biu_ack_i | bus.biu_err_i;

   pu_riscv_dext_tagq #(.DEPTH(DEPTH)) u_q (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (w_issue),
      .push_data_i (w_push_ent),
      .pop_i       (w_resp),
      .clr_mark_i  (bus.clr_i),
      .head_o      (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .count_o     (w_count)
   );

   // An ack coinciding with an error is reported as the error only.
   assign w_qual        = ~w_empty & ~w_head.discard & ~bus.clr_i;
   assign bus.mem_err_o = bus.biu_err_i & w_qual;
   assign bus.mem_ack_o = bus.biu_ack_i & ~bus.biu_err_i & w_qual;
   assign bus.mem_busy_o = ~w_empty;
   assign bus.mem_adr_o  = bus.biu_adro_i;

`ifdef PU_RISCV_DEXT_LOAD_ALIGN_EN
   logic [XLEN-1:0] w_sh, w_q;
   always_comb begin
      w_sh = bus.biu_q_i >> {w_head.adr_lo, 3'b000};
      case (w_head.size)
         HSIZE_BYTE:  w_q = XLEN'(w_sh[7:0]);
         HSIZE_HWORD: w_q = XLEN'(w_sh[15:0]);
         HSIZE_WORD:  w_q = XLEN'(w_sh[31:0]);
         default:     w_q = w_sh;
      endcase
      if (w_head.we) w_q = '0;
   end
   assign bus.mem_q_o = w_q;
`else
   assign bus.mem_q_o = bus.biu_q_i;
`endif

   assign w_unused = ^{w_head, w_count};

`ifndef SYNTHESIS
   a_resp_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_resp |-> !w_empty)
      else $error("dext: bus response with no outstanding transaction");
   a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_count <= CW'(DEPTH))
      else $error("dext: tracking queue count out of range");
`endif

endmodule

// File: tb/tb_pu_riscv_dext_mq.sv
// Directed, table-driven bench for pu_riscv_dext_mq (DEPTH=4, 64-bit).
module tb_pu_riscv_dext_mq;
   localparam logic [63:0] DX = 64'hD000_0000_0000_D000;
   localparam logic [63:0] Q1 = 64'hAABBCCDD_11223344;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pu_riscv_dext_mq_if #(.XLEN(64), .PLEN(64)) bus ();

   pu_riscv_dext_mq #(.XLEN(64), .PLEN(64), .DEPTH(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic        req, we, sack, ack, err, clr;
      logic [63:0] adr, q;
      logic [2:0]  size;
      logic        e_stb, e_aack, e_ack, e_err, e_busy;
      logic [2:0]  e_cnt;
      logic [63:0] e_adri;
      logic        chkq;
      logic [63:0] eq;
   } vec_t;

   function automatic vec_t mk(
      input logic req, we, input logic [63:0] adr, input logic [2:0] size,
      input logic sack, ack, err, clr, input logic [63:0] q,
      input logic e_stb, e_aack, e_ack, e_err, e_busy,
      input logic [2:0] e_cnt, input logic [63:0] e_adri);
      vec_t v;
      v.req = req; v.we = we; v.adr = adr; v.size = size;
      v.sack = sack; v.ack = ack; v.err = err; v.clr = clr; v.q = q;
      v.e_stb = e_stb; v.e_aack = e_aack; v.e_ack = e_ack; v.e_err = e_err;
      v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_adri = e_adri;
      v.chkq = 1'b0; v.eq = '0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.clr_i = 0; bus.mem_req_i = 0; bus.mem_adr_i = 0; bus.mem_size_i = 0;
      bus.mem_type_i = 0; bus.mem_lock_i = 0; bus.mem_prot_i = 0; bus.mem_we_i = 0;
      bus.mem_d_i = DX; bus.biu_stb_ack_i = 0; bus.biu_adro_i = 0; bus.biu_q_i = 0;
      bus.biu_ack_i = 0; bus.biu_err_i = 0;
   endtask

   // Drive one cycle, check combinational outputs, then step past the edge.
   task automatic apply(input vec_t v, input string nm);
      bus.mem_req_i = v.req; bus.mem_we_i = v.we; bus.mem_adr_i = v.adr;
      bus.mem_size_i = v.size; bus.mem_d_i = v.adr ^ DX; bus.mem_type_i = 3'd1;
      bus.mem_lock_i = 0; bus.mem_prot_i = 3'd2; bus.biu_stb_ack_i = v.sack;
      bus.biu_ack_i = v.ack; bus.biu_err_i = v.err; bus.clr_i = v.clr;
      bus.biu_q_i = v.q; bus.biu_adro_i = ~v.q;
      #1;
      chk({nm, ".stb"},  64'(bus.biu_stb_o),     64'(v.e_stb));
      chk({nm, ".aack"}, 64'(bus.mem_adr_ack_o), 64'(v.e_aack));
      chk({nm, ".ack"},  64'(bus.mem_ack_o),     64'(v.e_ack));
      chk({nm, ".err"},  64'(bus.mem_err_o),     64'(v.e_err));
      chk({nm, ".busy"}, 64'(bus.mem_busy_o),    64'(v.e_busy));
      chk({nm, ".cnt"},  64'(dut.u_q.count_o),   64'(v.e_cnt));
      chk({nm, ".adri"}, bus.biu_adri_o,         v.e_adri);
      chk({nm, ".d"},    bus.biu_d_o,            v.e_adri ^ DX);
      chk({nm, ".madr"}, bus.mem_adr_o,          ~v.q);
`ifdef PU_RISCV_DEXT_LOAD_ALIGN_EN
      if (v.chkq) chk({nm, ".q"}, bus.mem_q_o, v.eq);
`else
      chk({nm, ".q"}, bus.mem_q_o, v.q);
`endif
      @(posedge clk); #1;
   endtask

   vec_t tbl[19];

   initial begin
      //            req we adr       sz sk ak er cl q         stb aak ack err bsy cnt adri
      tbl[0]  = mk(1, 0, 64'h1004, 2, 1, 0, 0, 0, 0,        1, 1, 0, 0, 0, 0, 64'h1004);
      tbl[1]  = mk(0, 0, 0,        0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 1, 0);
      tbl[2]  = mk(0, 0, 0,        0, 0, 1, 0, 0, Q1,       0, 0, 1, 0, 1, 1, 0);
      tbl[2].chkq = 1'b1; tbl[2].eq = 64'hAABBCCDD;
      tbl[3]  = mk(0, 0, 0,        0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 1, 64'h100,  3, 1, 0, 0, 0, 0,        1, 1, 0, 0, 0, 0, 64'h100);
      tbl[5]  = mk(1, 1, 64'h108,  3, 1, 0, 0, 0, 0,        1, 1, 0, 0, 1, 1, 64'h108);
      tbl[6]  = mk(1, 1, 64'h110,  3, 1, 0, 0, 0, 0,        1, 1, 0, 0, 1, 2, 64'h110);
      tbl[7]  = mk(1, 1, 64'h118,  3, 1, 0, 0, 0, 0,        1, 1, 0, 0, 1, 3, 64'h118);
      tbl[8]  = mk(1, 1, 64'h120,  3, 1, 0, 0, 0, 0,        0, 0, 0, 0, 1, 4, 64'h120);
      tbl[9]  = mk(0, 0, 64'hDEAD0,0, 1, 0, 0, 0, 0,        0, 0, 0, 0, 1, 4, 64'h120);
      tbl[10] = mk(0, 0, 64'hDEAD0,0, 1, 1, 0, 0, 0,        0, 0, 1, 0, 1, 4, 64'h120);
      tbl[11] = mk(0, 0, 64'hDEAD0,0, 1, 0, 0, 0, 0,        1, 1, 0, 0, 1, 3, 64'h120);
      tbl[12] = mk(0, 0, 64'hDEAD0,0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 4, 64'hDEAD0);
      tbl[13] = mk(0, 0, 0,        0, 0, 1, 0, 0, 0,        0, 0, 1, 0, 1, 4, 0);
      tbl[14] = mk(1, 0, 64'h200,  3, 1, 1, 0, 0, 64'h55,   1, 1, 1, 0, 1, 3, 64'h200);
      tbl[15] = mk(0, 0, 0,        0, 0, 1, 0, 0, 0,        0, 0, 1, 0, 1, 3, 0);
      tbl[16] = mk(0, 0, 0,        0, 0, 1, 0, 0, 0,        0, 0, 1, 0, 1, 2, 0);
      tbl[17] = mk(0, 0, 0,        0, 0, 1, 0, 0, 64'h77,   0, 0, 1, 0, 1, 1, 0);
      tbl[18] = mk(0, 0, 0,        0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0);

      drive_idle();
      rst_n = 1'b0;
      #2;
      chk("rst.stb",  64'(bus.biu_stb_o),     0);
      chk("rst.aack", 64'(bus.mem_adr_ack_o), 0);
      chk("rst.ack",  64'(bus.mem_ack_o),     0);
      chk("rst.err",  64'(bus.mem_err_o),     0);
      chk("rst.busy", 64'(bus.mem_busy_o),    0);
      chk("rst.cnt",  64'(dut.u_q.count_o),   0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Flush with three loads in flight, one response landing in the flush cycle.
      apply(mk(1, 0, 64'h300, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h300), "clr0");
      apply(mk(1, 0, 64'h308, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 64'h308), "clr1");
      apply(mk(1, 0, 64'h310, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 2, 64'h310), "clr2");
      apply(mk(1, 0, 64'h318, 3, 1, 1, 0, 1, 0,  0, 0, 0, 0, 1, 3, 64'h318), "clr3");
      apply(mk(0, 0, 0,       0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 2, 0),       "clr4");
      apply(mk(0, 0, 0,       0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0),       "clr5");
      apply(mk(0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0),       "clr6");
      apply(mk(1, 0, 64'h400, 2, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h400), "clr7");
      apply(mk(0, 0, 0,       0, 0, 1, 0, 0, 64'h99, 0, 0, 1, 0, 1, 1, 0),   "clr8");
      apply(mk(0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0),       "clr9");

      // Error on the second of two loads, then ack+err together.
      apply(mk(1, 0, 64'h500, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h500), "err0");
      apply(mk(1, 0, 64'h508, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 64'h508), "err1");
      apply(mk(0, 0, 0,       0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 1, 2, 0),       "err2");
      apply(mk(0, 0, 0,       0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0),       "err3");
      apply(mk(0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0),       "err4");
      apply(mk(1, 0, 64'h510, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h510), "err5");
      apply(mk(0, 0, 0,       0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 1, 0),       "err6");
      apply(mk(0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0),       "err7");

      // Async reset with two outstanding and a request held.
      apply(mk(1, 0, 64'h600, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h600), "ar0");
      apply(mk(1, 0, 64'h608, 3, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 64'h608), "ar1");
      apply(mk(1, 0, 64'h610, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2, 64'h610), "ar2");
      drive_idle();
      #1;
      chk("ar.pre_stb",  64'(bus.biu_stb_o), 1);
      chk("ar.pre_adri", bus.biu_adri_o,     64'h610);
      rst_n = 1'b0;
      bus.biu_ack_i = 1'b1;
      #1;
      chk("ar.stb",  64'(bus.biu_stb_o),   0);
      chk("ar.busy", 64'(bus.mem_busy_o),  0);
      chk("ar.ack",  64'(bus.mem_ack_o),   0);
      chk("ar.cnt",  64'(dut.u_q.count_o), 0);
      chk("ar.adri", bus.biu_adri_o,       0);
      bus.biu_ack_i = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      apply(mk(1, 0, 64'h700, 2, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 64'h700), "ar3");
      apply(mk(0, 0, 0,       0, 0, 1, 0, 0, 64'h12, 0, 0, 1, 0, 1, 1, 0),   "ar4");
      apply(mk(0, 0, 0,       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0),       "ar5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
